// File: rtl/md_pipe_ctrl.sv
// md_pipe_ctrl -- multiply/divide sequencer and MDU stall scheduler.
//
// Takes MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns HI/LO.
// A mult/div computes its 64-bit result when it is accepted, holds it in a
// pending register, counts out a fixed latency, and only then writes HI/LO.
// While the MDU is busy, any MDU-using instruction in D is held: F and D
// freeze and a bubble is inserted into E.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   E_md_op[3:0]    E-stage op: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//   E_A, E_B        forwarded rs / rt values in E
//   D_md_use        D-stage instruction uses the MDU
//   hazard_stall    stall request from the data-hazard unit
//   md_busy         MDU operation in progress
//   HI, LO          architectural HI/LO registers
//   F_en, D_en      PC/F and D pipeline register enables
//   E_clr           synchronous clear (bubble) of the E register
module md_pipe_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md_use,
    input  logic        hazard_stall,
    output logic        md_busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        F_en,
    output logic        D_en,
    output logic        E_clr
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   pend_q, pend_d;
    logic          pend_wr_q, pend_wr_d;   // 0 for divide-by-zero: leave HI/LO alone
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    logic          start, is_mul, stall;
    logic [63:0]   prod_s, prod_u, res;
    logic          res_wr;

    // Divider works on magnitudes; signs are restored afterwards so the
    // quotient truncates toward zero and the remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    logic          sdiv;
    logic [31:0]   a_mag, b_mag, b_div, q_mag, r_mag, q_res, r_res;

    assign is_mul = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU);
    assign start  = (state_q == IDLE) &&
                    (is_mul || (E_md_op == OP_DIV) || (E_md_op == OP_DIVU));

    assign prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    assign prod_u = {32'd0, E_A} * {32'd0, E_B};

    assign sdiv  = (E_md_op == OP_DIV);
    assign a_mag = (sdiv && E_A[31]) ? (~E_A + 32'd1) : E_A;
    assign b_mag = (sdiv && E_B[31]) ? (~E_B + 32'd1) : E_B;
    assign b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / b_div;
    assign r_mag = a_mag % b_div;
    assign q_res = (sdiv && (E_A[31] ^ E_B[31])) ? (~q_mag + 32'd1) : q_mag;
    assign r_res = (sdiv && E_A[31]) ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res    = {r_res, q_res};
        res_wr = (E_B != 32'd0);
        case (E_md_op)
            OP_MULT:  begin res = prod_s; res_wr = 1'b1; end
            OP_MULTU: begin res = prod_u; res_wr = 1'b1; end
            default:  ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = BUSY;
                    cnt_d     = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    pend_d    = res;
                    pend_wr_d = res_wr;
                end else if (E_md_op == OP_MTHI) begin
                    hi_d = E_A;
                end else if (E_md_op == OP_MTLO) begin
                    lo_d = E_A;
                end
            end
            BUSY: begin
                // Ops arriving here are protocol violations and are ignored.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign md_busy = (state_q == BUSY);
    assign HI      = hi_q;
    assign LO      = lo_q;

    // The E instruction that starts an op still advances; only D/F hold.
    assign stall = hazard_stall | (D_md_use & (start | md_busy));
    assign F_en  = ~stall;
    assign D_en  = ~stall;
    assign E_clr = stall;

endmodule

// File: tb/tb_md_pipe_ctrl.sv
module tb_md_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  E_md_op = 4'd0;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        D_md_use = 1'b0;
    logic        hazard_stall = 1'b0;
    logic        md_busy, F_en, D_en, E_clr;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;

    md_pipe_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_md_op(E_md_op), .E_A(E_A), .E_B(E_B),
        .D_md_use(D_md_use), .hazard_stall(hazard_stall), .md_busy(md_busy),
        .HI(HI), .LO(LO), .F_en(F_en), .D_en(D_en), .E_clr(E_clr)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: present an op for one cycle, then clear it.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        E_md_op = op; E_A = a; E_B = b;
        step();
        E_md_op = 4'd0;
    endtask

    // Count remaining busy cycles (bounded).
    task automatic count_busy(inout int n);
        while (md_busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++;
        if (md_busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || D_en !== 1'b1 || F_en !== 1'b1 || E_clr !== 1'b0) begin
            failures++;
            $display("FAIL reset: busy=%b HI=%h LO=%h D_en=%b F_en=%b E_clr=%b want 0/0/0/1/1/0",
                     md_busy, HI, LO, D_en, F_en, E_clr);
        end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        n = 0;
        issue(4'd1, 32'hFFFFFFFD, 32'd5);
        count_busy(n);
        checks++;
        if (n !== 5 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF1) begin
            failures++;
            $display("FAIL mult: busy=%0d HI=%h LO=%h want 5 ffffffff fffffff1", n, HI, LO);
        end
        n = 0;
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        count_busy(n);
        checks++;
        if (n !== 5 || HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
            failures++;
            $display("FAIL multu: busy=%0d HI=%h LO=%h want 5 fffffffe 00000001", n, HI, LO);
        end
    endtask

    // DIV -7/2 with an mfhi waiting in D from the start cycle onward.
    task automatic test_stall_div();
        int n;
        int bad;
        n = 0; bad = 0;
        D_md_use = 1'b1;
        E_md_op = 4'd3; E_A = 32'hFFFFFFF9; E_B = 32'd2;
        #1;
        checks++;
        if (D_en !== 1'b0 || F_en !== 1'b0 || E_clr !== 1'b1 || md_busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_start: D_en=%b F_en=%b E_clr=%b busy=%b want 0 0 1 0", D_en, F_en, E_clr, md_busy);
        end
        step();
        E_md_op = 4'd0;
        while (md_busy === 1'b1 && n < 40) begin
            if (D_en !== 1'b0 || F_en !== 1'b0 || E_clr !== 1'b1) bad++;
            n++;
            step();
        end
        checks++;
        if (n !== 10 || bad !== 0) begin
            failures++;
            $display("FAIL stall_busy: busy=%0d bad_stall_cycles=%0d want 10 0", n, bad);
        end
        checks++;
        if (D_en !== 1'b1 || F_en !== 1'b1 || E_clr !== 1'b0 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL stall_release: D_en=%b E_clr=%b HI=%h LO=%h want 1 0 ffffffff fffffffd", D_en, E_clr, HI, LO);
        end
        D_md_use = 1'b0;
    endtask

    task automatic test_div_signs();
        int n;
        n = 0;
        issue(4'd4, 32'd7, 32'd2);
        count_busy(n);
        checks++;
        if (n !== 10 || HI !== 32'd1 || LO !== 32'd3) begin
            failures++;
            $display("FAIL divu: busy=%0d HI=%h LO=%h want 10 1 3", n, HI, LO);
        end
        n = 0;
        issue(4'd3, 32'd7, 32'hFFFFFFFE);
        count_busy(n);
        checks++;
        if (HI !== 32'd1 || LO !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL div_negdivisor: HI=%h LO=%h want 00000001 fffffffd", HI, LO);
        end
        n = 0;
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        count_busy(n);
        checks++;
        if (HI !== 32'd0 || LO !== 32'h80000000) begin
            failures++;
            $display("FAIL div_overflow: HI=%h LO=%h want 00000000 80000000", HI, LO);
        end
    endtask

    task automatic test_mt_div0();
        int n;
        n = 0;
        issue(4'd5, 32'h11, 32'd0);
        D_md_use = 1'b1;
        E_md_op = 4'd6; E_A = 32'h22;
        #1;
        checks++;
        if (D_en !== 1'b1 || E_clr !== 1'b0) begin
            failures++;
            $display("FAIL mt_nostall: D_en=%b E_clr=%b want 1 0", D_en, E_clr);
        end
        step();
        E_md_op = 4'd0; D_md_use = 1'b0;
        checks++;
        if (HI !== 32'h11 || LO !== 32'h22 || md_busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi_mtlo: HI=%h LO=%h busy=%b want 11 22 0", HI, LO, md_busy);
        end
        issue(4'd4, 32'd1234, 32'd0);
        count_busy(n);
        checks++;
        if (n !== 10 || HI !== 32'h11 || LO !== 32'h22) begin
            failures++;
            $display("FAIL divu_by_zero: busy=%0d HI=%h LO=%h want 10 11 22", n, HI, LO);
        end
    endtask

    // Ops presented while busy must not disturb the running divide.
    task automatic test_protocol();
        int n;
        n = 1;
        issue(4'd4, 32'd100, 32'd7);
        issue(4'd1, 32'd3, 32'd3);
        issue(4'd5, 32'hDEAD, 32'd0);
        issue(4'd6, 32'hBEEF, 32'd0);
        n = 3;
        count_busy(n);
        checks++;
        if (n !== 10 || HI !== 32'd2 || LO !== 32'd14) begin
            failures++;
            $display("FAIL ignore_while_busy: busy=%0d HI=%h LO=%h want 10 2 e", n, HI, LO);
        end
    endtask

    task automatic test_hazard_start();
        int n;
        n = 0;
        hazard_stall = 1'b1;
        E_md_op = 4'd2; E_A = 32'd6; E_B = 32'd7;
        #1;
        checks++;
        if (D_en !== 1'b0 || E_clr !== 1'b1) begin
            failures++;
            $display("FAIL hazard_stall: D_en=%b E_clr=%b want 0 1", D_en, E_clr);
        end
        step();
        E_md_op = 4'd0; hazard_stall = 1'b0;
        count_busy(n);
        checks++;
        if (n !== 5 || HI !== 32'd0 || LO !== 32'd42) begin
            failures++;
            $display("FAIL hazard_start: busy=%0d HI=%h LO=%h want 5 0 2a", n, HI, LO);
        end
    endtask

    task automatic test_reset_mid();
        int chg;
        chg = 0;
        D_md_use = 1'b1;
        issue(4'd1, 32'd9, 32'd9);   // busy cycle 1
        step();                      // busy cycle 2
        step();                      // busy cycle 3
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (md_busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || D_en !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: busy=%b HI=%h LO=%h D_en=%b want 0 0 0 1", md_busy, HI, LO, D_en);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (HI !== 32'd0 || LO !== 32'd0 || md_busy !== 1'b0) chg++;
        end
        checks++;
        if (chg !== 0) begin
            failures++;
            $display("FAIL reset_abort: late_change_cycles=%0d want 0", chg);
        end
        D_md_use = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_stall_div();
        test_div_signs();
        test_mt_div0();
        test_protocol();
        test_hazard_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_pipe_ctrl.md
Name: md_pipe_ctrl

Overview:
- Multiply/divide sequencer and stall scheduler for the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the E stage and owns the HI/LO registers.
- Counts out a fixed operation latency.
- Drives the enable/clear controls of the F/D/E pipeline registers so that any MDU-using instruction in D waits until HI/LO are final.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- E_md_op  input  4  E-stage op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, others = none
- E_A  input  32  forwarded rs value in E
- E_B  input  32  forwarded rt value in E
- D_md_use  input  1  D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
- hazard_stall  input  1  stall request from the data-hazard unit
- md_busy  output  1  MDU operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- F_en  output  1  PC/F register enable
- D_en  output  1  D register enable
- E_clr  output  1  synchronous clear (bubble) of the E register

Behaviour:
- Reset (reset=1 at posedge): state=IDLE, counter=0, HI=0, LO=0, md_busy=0, any pending result discarded. Reset mid-operation aborts the operation with no HI/LO update.
- States: IDLE, BUSY.
- start = (state==IDLE) & E_md_op in {1..4}.
- IDLE -> BUSY on start:
  - counter loaded with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Result computed from E_A/E_B at that edge and held in an internal 64-bit pending register.
- BUSY:
  - Counter decrements each cycle.
  - On the edge where counter==1: HI/LO take the pending result, state -> IDLE.
  - md_busy=1 exactly N cycles (t+1..t+N) for a start in cycle t. New HI/LO visible in cycle t+N+1.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend (E_A).
  - DIVU: LO = quotient, HI = remainder, unsigned.
  - DIV/DIVU with E_B==0: full DIV_CYCLES busy period, HI/LO unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO in IDLE: HI (resp. LO) <= E_A at the next edge; md_busy stays 0.
- Any E_md_op 1..6 while BUSY is a protocol violation and is ignored; HI/LO and the counter are unaffected. The stall logic prevents this in a correct pipeline.
- Stall (combinational):
  - stall = hazard_stall | (D_md_use & (start | md_busy)).
  - F_en = D_en = ~stall; E_clr = stall.
  - The E instruction itself advances to M normally. Only D and F freeze, and a bubble enters E.
- Stall release: the cycle after the completion edge has md_busy=0, so D_md_use no longer stalls. An mfhi released then reads the final HI.
- hazard_stall during IDLE with start: start still occurs, because the E-stage op is not held back.

Test Plan:
- MULT E_A=0xFFFFFFFD (-3), E_B=5 -> md_busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- D_md_use=1 (mfhi) in D from the start cycle onward -> D_en=F_en=0 and E_clr=1 in the start cycle and all 10 busy cycles; D_en=1 in the cycle after md_busy falls, with HI final.
- DIVU E_B=0 with prior HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO remain 0x11/0x22.
- MULT started, reset asserted in busy cycle 3 -> next cycle md_busy=0, HI=LO=0, D_en=1; no later HI/LO change.
- MTLO E_A=0x1234 in IDLE -> LO=0x1234 next cycle, md_busy=0, no stall generated.
